// File: rtl/adpll_tx_ser_pkg.sv
// ---------------------------------------------------------------------------
// adpll_tx_ser_pkg
// Shared constants for the ADPLL TX bit serializer: local register
// addresses, FSM state encoding, register reset values and the whitening
// LFSR step function.
// Optional feature macro: ADPLL_TX_SER_WHITEN_EN (enables the whitening
// LFSR and the WHITEN_SEED register).
// ---------------------------------------------------------------------------
package adpll_tx_ser_pkg;

    localparam logic [2:0] TX_SER_ADDR_DATA   = 3'd0;
    localparam logic [2:0] TX_SER_ADDR_DIV    = 3'd1;
    localparam logic [2:0] TX_SER_ADDR_EN     = 3'd2;
    localparam logic [2:0] TX_SER_ADDR_STATUS = 3'd3;
    localparam logic [2:0] TX_SER_ADDR_CLR    = 3'd4;
    localparam logic [2:0] TX_SER_ADDR_SEED   = 3'd5;

    // 16 MHz / (15 + 1) = 1 Mbps
    localparam logic [7:0] TX_SER_DIV_RST  = 8'd15;
    localparam logic [6:0] TX_SER_SEED_RST = 7'h53;

    typedef enum logic {
        TX_ST_IDLE  = 1'b0,
        TX_ST_SHIFT = 1'b1
    } tx_ser_state_e;

    // x^7 + x^4 + 1 Fibonacci step; the output bit is s[6]
    function automatic logic [6:0] tx_ser_lfsr_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[3]};
    endfunction

endpackage

// File: rtl/adpll_tx_fifo.sv
// ---------------------------------------------------------------------------
// adpll_tx_fifo
// Synchronous byte FIFO feeding the TX serializer.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     enqueue request and data (dropped when full unless a
//                   pop happens in the same cycle)
//   pop             dequeue request (ignored when empty)
//   flush           empties the FIFO; overrides push and pop
//   rdata           current head entry
//   level           occupancy 0..2^AW
//   full, empty     occupancy flags
// ---------------------------------------------------------------------------
module adpll_tx_fifo #(
    parameter int AW = 3,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full  = (level_q == DEPTH_L);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        // a pop frees the head slot this cycle, so a push is accepted when full
        do_push  = push & (~full | pop) & ~flush;
        do_pop   = pop & ~empty & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // storage needs no reset: level gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/adpll_tx_ser.sv
// ---------------------------------------------------------------------------
// adpll_tx_ser
// CPU-fed TX bit serializer driving the ADPLL data_mod input. Bytes pushed
// into a FIFO are shifted out LSB first as a continuous NRZ stream, one bit
// every DIV+1 clocks.
// Optional feature macro: ADPLL_TX_SER_WHITEN_EN -- XORs the stream with a
// x^7+x^4+1 LFSR seeded from WHITEN_SEED at the start of each burst.
// Ports:
//   clk, rst       16 MHz reference clock, asynchronous active-high reset
//   valid, address, wdata, wstrb   CPU access (wstrb=1 write, 0 read)
//   rdata          read data, combinational on address
//   ready          valid delayed one clock
//   data_mod       serial bit to the modulator (0 when idle)
//   tx_active      high while in SHIFT
//   tx_done_irq    level copy of the sticky done flag
// ---------------------------------------------------------------------------
module adpll_tx_ser
    import adpll_tx_ser_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int DIV_W   = 8,
    parameter int ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       wdata,
    input  logic              wstrb,
    output logic [7:0]        rdata,
    output logic              ready,
    output logic              data_mod,
    output logic              tx_active,
    output logic              tx_done_irq
);

    tx_ser_state_e      state_q, state_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               en_q, en_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               ready_q, ready_d;

    logic               wr_en, push, pop, done_set, ovf_set;
    logic [2:0]         clr;
    logic [7:0]         fifo_head;
    logic [FIFO_AW:0]   fifo_level;
    logic               fifo_full, fifo_empty;
    logic               wbit;

`ifdef ADPLL_TX_SER_WHITEN_EN
    logic [6:0]         seed_q, seed_d;
    logic [6:0]         lfsr_q, lfsr_d;
`endif

    logic unused_wdata;
    assign unused_wdata = ^wdata;

    adpll_tx_fifo #(
        .AW (FIFO_AW),
        .W  (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (clr[0]),
        .wdata (wdata[7:0]),
        .rdata (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- register writes ----------------
    always_comb begin
        wr_en   = valid & wstrb;
        ready_d = valid;
        push    = 1'b0;
        clr     = '0;
        div_d   = div_q;
        en_d    = en_q;
`ifdef ADPLL_TX_SER_WHITEN_EN
        seed_d  = seed_q;
`endif
        if (wr_en) begin
            case (address)
                ADDR_W'(TX_SER_ADDR_DATA): push  = 1'b1;
                ADDR_W'(TX_SER_ADDR_DIV):  div_d = wdata[DIV_W-1:0];
                ADDR_W'(TX_SER_ADDR_EN):   en_d  = wdata[0];
                ADDR_W'(TX_SER_ADDR_CLR):  clr   = wdata[2:0];
`ifdef ADPLL_TX_SER_WHITEN_EN
                ADDR_W'(TX_SER_ADDR_SEED): seed_d = wdata[6:0];
`endif
                default: ;
            endcase
        end
    end

    // ---------------- register reads ----------------
    always_comb begin
        rdata = 8'hFF;
        case (address)
            ADDR_W'(TX_SER_ADDR_DATA):   rdata = 8'h00;
            ADDR_W'(TX_SER_ADDR_DIV):    rdata = 8'(div_q);
            ADDR_W'(TX_SER_ADDR_EN):     rdata = {7'b0, en_q};
            ADDR_W'(TX_SER_ADDR_STATUS): rdata = {ovf_q, done_q, fifo_full,
                                                  fifo_empty, 4'(fifo_level)};
            ADDR_W'(TX_SER_ADDR_CLR):    rdata = 8'h00;
`ifdef ADPLL_TX_SER_WHITEN_EN
            ADDR_W'(TX_SER_ADDR_SEED):   rdata = {1'b0, seed_q};
`endif
            default:                     rdata = 8'hFF;
        endcase
    end

    // ---------------- FSM next state / datapath ----------------
    // en_d is used so that clearing EN aborts on the very edge the write lands.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        pop       = 1'b0;
        done_set  = 1'b0;
`ifdef ADPLL_TX_SER_WHITEN_EN
        lfsr_d    = lfsr_q;
`endif
        unique case (state_q)
            TX_ST_IDLE: begin
                if (en_d && !fifo_empty) begin
                    pop       = 1'b1;
                    shreg_d   = fifo_head;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = TX_ST_SHIFT;
`ifdef ADPLL_TX_SER_WHITEN_EN
                    lfsr_d    = seed_q;
`endif
                end
            end
            TX_ST_SHIFT: begin
                if (!en_d) begin
                    state_d = TX_ST_IDLE;
                end else if (div_cnt_q == div_q) begin
                    div_cnt_d = '0;
`ifdef ADPLL_TX_SER_WHITEN_EN
                    lfsr_d    = tx_ser_lfsr_step(lfsr_q);
`endif
                    if (bit_cnt_q == 3'd7) begin
                        // back-to-back reload keeps the stream gap-free
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            shreg_d   = fifo_head;
                            bit_cnt_d = '0;
                        end else begin
                            state_d  = TX_ST_IDLE;
                            done_set = 1'b1;
                        end
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = TX_ST_IDLE;
        endcase
    end

    // sticky flags: a set in the same cycle as a clear wins
    always_comb begin
        ovf_set = push & fifo_full & ~pop;
        done_d  = (done_q & ~clr[1]) | done_set;
        ovf_d   = (ovf_q & ~clr[2]) | ovf_set;
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
`ifdef ADPLL_TX_SER_WHITEN_EN
        wbit = lfsr_q[6];
`else
        wbit = 1'b0;
`endif
        tx_active   = (state_q == TX_ST_SHIFT);
        data_mod    = tx_active ? (shreg_q[0] ^ wbit) : 1'b0;
        tx_done_irq = done_q;
        ready       = ready_q;
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            div_q     <= DIV_W'(TX_SER_DIV_RST);
            en_q      <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b0;
`ifdef ADPLL_TX_SER_WHITEN_EN
            seed_q    <= TX_SER_SEED_RST;
            lfsr_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            div_q     <= div_d;
            en_q      <= en_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            ready_q   <= ready_d;
`ifdef ADPLL_TX_SER_WHITEN_EN
            seed_q    <= seed_d;
            lfsr_q    <= lfsr_d;
`endif
        end
    end

endmodule
